// File: rtl/ula_seq_pkg.sv
// ---------------------------------------------------------------------------
// ula_seq_pkg
// Purpose : shared types and constants for the multi-precision ALU sequencer.
// Contents: FSM state enum, ALU select codes, carry-polarity helper.
// ---------------------------------------------------------------------------
package ula_seq_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned SEL_W  = 4;

   // ALU function select codes
   localparam logic [SEL_W-1:0] ALU_S_ADD    = 4'b1001;
   localparam logic [SEL_W-1:0] ALU_S_SUB_M1 = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Functions for which the ALU reports a complemented carry out
   function automatic logic carry_inverted(input logic [SEL_W-1:0] s);
      logic inv;
      case (s)
         4'b0000, 4'b0010, 4'b0011,
         4'b0110, 4'b0111, 4'b1011: inv = 1'b1;
         default:                   inv = 1'b0;
      endcase
      return inv;
   endfunction

endpackage : ula_seq_pkg

// File: rtl/ula_seq_if.sv
// ---------------------------------------------------------------------------
// ula_seq_if
// Purpose : command/response channel between the issuer and ula_seq_ctrl.
// Signals : cmd_valid/cmd_ready handshake with cmd_m, cmd_s, cmd_cin,
//           cmd_a, cmd_b payload; rsp_valid/rsp_ready handshake with
//           rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_eq payload.
// Modports: master = command issuer, slave = sequencer.
// ---------------------------------------------------------------------------
interface ula_seq_if #(
   parameter int unsigned NBYTES = 4
);
   localparam int unsigned W = 8 * NBYTES;

   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_m;
   logic [3:0]   cmd_s;
   logic         cmd_cin;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_f;
   logic         rsp_cout;
   logic         rsp_ovf;
   logic         rsp_zero;
   logic         rsp_eq;

   modport master (
      output cmd_valid, cmd_m, cmd_s, cmd_cin, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_eq
   );

   modport slave (
      input  cmd_valid, cmd_m, cmd_s, cmd_cin, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_eq
   );

endinterface : ula_seq_if

// File: rtl/ula_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ula_seq_ctrl
// Purpose : drives an 8-bit ALU byte-serially (LSB first) to execute one
//           NBYTES-wide operation, chaining carry between bytes, and returns
//           the wide result and status on a valid/ready response channel.
// Ports   : clk, rst_n (async, active-low)
//           bus      - ula_seq_if.slave command/response channel
//           alu_a/b/s/m/cin  - ALU inputs (combinational, zero/idle outside RUN)
//           alu_f/cout/ovf/a_eq_b - ALU outputs
// Config  : ULA_SEQ_BACK2BACK_EN - when defined, a new command may be accepted
//           in the same cycle as the response handshake (skips IDLE).
// ---------------------------------------------------------------------------
module ula_seq_ctrl
   import ula_seq_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   ula_seq_if.slave    bus,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_s,
   output logic        alu_m,
   output logic        alu_cin,
   input  logic [7:0]  alu_f,
   input  logic        alu_cout,
   input  logic        alu_ovf,
   input  logic        alu_a_eq_b
);

   localparam int unsigned W        = BYTE_W * NBYTES;
   localparam int unsigned IDX_W    = $clog2(NBYTES);
   localparam int unsigned LAST_IDX = NBYTES - 1;

   state_t             r_state,  w_state_nxt;
   logic [W-1:0]       r_a,      w_a_nxt;
   logic [W-1:0]       r_b,      w_b_nxt;
   logic               r_m,      w_m_nxt;
   logic [SEL_W-1:0]   r_s,      w_s_nxt;
   logic               r_carry,  w_carry_nxt;
   logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
   logic               r_eq_acc, w_eq_acc_nxt;
   logic [W-1:0]       r_f,      w_f_nxt;
   logic               r_cout,   w_cout_nxt;
   logic               r_ovf,    w_ovf_nxt;
   logic               r_zero,   w_zero_nxt;
   logic               r_eq,     w_eq_nxt;

   logic               w_cmd_ready;
   logic               w_rsp_valid;
   logic               w_load;
   logic [IDX_W+2:0]   w_bit_base;

   assign w_bit_base = {r_idx, 3'b000};

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_m      <= 1'b0;
         r_s      <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_eq_acc <= 1'b0;
         r_f      <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_eq     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_m      <= w_m_nxt;
         r_s      <= w_s_nxt;
         r_carry  <= w_carry_nxt;
         r_idx    <= w_idx_nxt;
         r_eq_acc <= w_eq_acc_nxt;
         r_f      <= w_f_nxt;
         r_cout   <= w_cout_nxt;
         r_ovf    <= w_ovf_nxt;
         r_zero   <= w_zero_nxt;
         r_eq     <= w_eq_nxt;
      end
   end

   // Next-state, datapath update and ALU drive
   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_m_nxt      = r_m;
      w_s_nxt      = r_s;
      w_carry_nxt  = r_carry;
      w_idx_nxt    = r_idx;
      w_eq_acc_nxt = r_eq_acc;
      w_f_nxt      = r_f;
      w_cout_nxt   = r_cout;
      w_ovf_nxt    = r_ovf;
      w_zero_nxt   = r_zero;
      w_eq_nxt     = r_eq;
      w_cmd_ready  = 1'b0;
      w_rsp_valid  = 1'b0;
      w_load       = 1'b0;
      alu_a        = 8'h00;
      alu_b        = 8'h00;
      alu_s        = 4'h0;
      alu_m        = 1'b1;
      alu_cin      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cmd_ready = 1'b1;
            w_load      = bus.cmd_valid;
         end

         ST_RUN: begin
            alu_a   = r_a[w_bit_base +: BYTE_W];
            alu_b   = r_b[w_bit_base +: BYTE_W];
            alu_s   = r_s;
            alu_m   = r_m;
            alu_cin = r_carry;

            w_f_nxt[w_bit_base +: BYTE_W] = alu_f;
            w_eq_acc_nxt = r_eq_acc & alu_a_eq_b;

            // Normalise the ALU's carry polarity before chaining it onward
            if (!r_m) begin
               w_carry_nxt = carry_inverted(r_s) ? ~alu_cout : alu_cout;
            end

            if (r_idx == IDX_W'(LAST_IDX)) begin
               w_cout_nxt  = r_m ? 1'b0 : alu_cout;
               w_ovf_nxt   = r_m ? 1'b0 : alu_ovf;
               w_zero_nxt  = (w_f_nxt == '0);
               w_eq_nxt    = w_eq_acc_nxt;
               w_state_nxt = ST_DONE;
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end

         ST_DONE: begin
            w_rsp_valid = 1'b1;
`ifdef ULA_SEQ_BACK2BACK_EN
            w_cmd_ready = bus.rsp_ready;
            w_load      = bus.rsp_ready & bus.cmd_valid;
`else
            w_cmd_ready = 1'b0;
`endif
            if (bus.rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Command capture overrides whatever the state chose
      if (w_load) begin
         w_a_nxt      = bus.cmd_a;
         w_b_nxt      = bus.cmd_b;
         w_m_nxt      = bus.cmd_m;
         w_s_nxt      = bus.cmd_s;
         w_carry_nxt  = bus.cmd_cin;
         w_idx_nxt    = '0;
         w_eq_acc_nxt = 1'b1;
         w_state_nxt  = ST_RUN;
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_f     = r_f;
   assign bus.rsp_cout  = r_cout;
   assign bus.rsp_ovf   = r_ovf;
   assign bus.rsp_zero  = r_zero;
   assign bus.rsp_eq    = r_eq;

endmodule : ula_seq_ctrl

// File: tb/tb_ula_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ula_seq_ctrl
// Purpose : directed self-checking bench for ula_seq_ctrl (NBYTES=4) with a
//           small behavioural 8-bit ALU standing in for ula_8_bits.
// ---------------------------------------------------------------------------
module tb_ula_seq_ctrl;
   import ula_seq_pkg::*;

   localparam int unsigned NB = 4;
   localparam int unsigned W  = 8 * NB;

   logic       clk;
   logic       rst_n;
   logic [7:0] alu_a, alu_b, alu_f;
   logic [3:0] alu_s;
   logic       alu_m, alu_cin, alu_cout, alu_ovf, alu_a_eq_b;

   int n_checks;
   int n_errors;

   ula_seq_if #(.NBYTES(NB)) bus ();

   ula_seq_ctrl #(.NBYTES(NB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_s      (alu_s),
      .alu_m      (alu_m),
      .alu_cin    (alu_cin),
      .alu_f      (alu_f),
      .alu_cout   (alu_cout),
      .alu_ovf    (alu_ovf),
      .alu_a_eq_b (alu_a_eq_b)
   );

   // Behavioural ALU: ADD is A+B+cin with true carry; SUB_M1 is A+~B+cin
   // reporting the complemented carry (i.e. borrow). Logic mode reports
   // cout/ovf as 1 so the sequencer's forcing to 0 is visible.
   logic [7:0] m_y;
   logic [8:0] m_sum;
   always_comb begin
      m_y        = (alu_s == 4'b0110) ? ~alu_b : alu_b;
      m_sum      = {1'b0, alu_a} + {1'b0, m_y} + 9'(alu_cin);
      alu_a_eq_b = (alu_a == alu_b);
      alu_f      = alu_a;
      alu_cout   = 1'b0;
      alu_ovf    = 1'b0;
      if (!alu_m) begin
         if (alu_s == 4'b1001 || alu_s == 4'b0110) begin
            alu_f    = m_sum[7:0];
            alu_cout = (alu_s == 4'b0110) ? ~m_sum[8] : m_sum[8];
            alu_ovf  = (alu_a[7] == m_y[7]) && (m_sum[7] != alu_a[7]);
         end
      end else begin
         case (alu_s)
            4'b0110: alu_f = alu_a ^ alu_b;
            4'b1011: alu_f = alu_a & alu_b;
            4'b1110: alu_f = alu_a | alu_b;
            default: alu_f = ~alu_a;
         endcase
         alu_cout = 1'b1;
         alu_ovf  = 1'b1;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command; returns the number of cycles until rsp_valid.
   // With hold_valid, cmd_valid stays high and cmd_ready must stay low.
   task automatic issue(input string tag, input logic m, input logic [3:0] s,
                        input logic cin, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold_valid, output int lat);
      @(negedge clk);
      bus.cmd_m     = m;
      bus.cmd_s     = s;
      bus.cmd_cin   = cin;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_valid = 1'b1;
      check({tag, " ready_idle"}, W'(bus.cmd_ready), W'(1));
      @(posedge clk);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (!hold_valid) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_a     = '1;
            bus.cmd_b     = '1;
            bus.cmd_cin   = ~cin;
         end else begin
            check({tag, " ready_busy"}, W'(bus.cmd_ready), W'(0));
         end
         if (bus.rsp_valid) break;
      end
      if (!bus.rsp_valid) check({tag, " rsp_timeout"}, W'(bus.rsp_valid), W'(1));
   endtask

   // Check the held response, then complete the handshake
   task automatic finish_rsp(input string tag, input int lat, input logic [W-1:0] f,
                             input logic cout, input logic ovf, input logic zero,
                             input logic eq);
      check({tag, " latency"}, W'(lat), W'(5));
      check({tag, " f"},    bus.rsp_f, f);
      check({tag, " cout"}, W'(bus.rsp_cout), W'(cout));
      check({tag, " ovf"},  W'(bus.rsp_ovf),  W'(ovf));
      check({tag, " zero"}, W'(bus.rsp_zero), W'(zero));
      check({tag, " eq"},   W'(bus.rsp_eq),   W'(eq));
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, " valid_drop"}, W'(bus.rsp_valid), W'(0));
      check({tag, " ready_back"}, W'(bus.cmd_ready), W'(1));
   endtask

   initial begin
      int lat;
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_m     = 1'b0;
      bus.cmd_s     = 4'h0;
      bus.cmd_cin   = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst cmd_ready", W'(bus.cmd_ready), W'(1));
      check("rst rsp_valid", W'(bus.rsp_valid), W'(0));
      check("rst rsp_f",     bus.rsp_f,         W'(0));
      check("rst alu_m",     W'(alu_m),         W'(1));

      // 0xFF + 1 carries across byte 0, with 3 cycles of backpressure
      issue("add_carry", 1'b0, ALU_S_ADD, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp valid", W'(bus.rsp_valid), W'(1));
         check("bp f",     bus.rsp_f,         32'h0000_0100);
      end
      finish_rsp("add_carry", lat, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);

      issue("add_wrap", 1'b0, ALU_S_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
      finish_rsp("add_wrap", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

      issue("sub", 1'b0, ALU_S_SUB_M1, 1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, lat);
      finish_rsp("sub", lat, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);

      issue("add_ovf", 1'b0, ALU_S_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
      finish_rsp("add_ovf", lat, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

      issue("xor", 1'b1, 4'b0110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, lat);
      check("xor ready_done", W'(bus.cmd_ready), W'(0));
      finish_rsp("xor", lat, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);

      issue("add_eq", 1'b0, ALU_S_ADD, 1'b0, 32'h0101_0101, 32'h0101_0101, 1'b0, lat);
      finish_rsp("add_eq", lat, 32'h0202_0202, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of RUN
      @(negedge clk);
      bus.cmd_m     = 1'b0;
      bus.cmd_s     = ALU_S_ADD;
      bus.cmd_cin   = 1'b0;
      bus.cmd_a     = 32'hFFFF_FFFF;
      bus.cmd_b     = 32'hFFFF_FFFF;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("run busy", W'(bus.cmd_ready), W'(0));
      rst_n = 1'b0;
      #1;
      check("mid rst cmd_ready", W'(bus.cmd_ready), W'(1));
      check("mid rst rsp_valid", W'(bus.rsp_valid), W'(0));
      check("mid rst rsp_f",     bus.rsp_f,         W'(0));
      check("mid rst flags",
            W'({bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero, bus.rsp_eq}), W'(0));
      check("mid rst alu_a",     W'(alu_a),         W'(0));
      check("mid rst alu_m",     W'(alu_m),         W'(1));
      @(negedge clk);
      rst_n = 1'b1;

      issue("post_rst", 1'b0, ALU_S_ADD, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, lat);
      finish_rsp("post_rst", lat, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ula_seq_ctrl

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
- Multi-precision sequencer for the 8-bit ALU (ula_8_bits). Accepts one NBYTES-wide command and drives the ALU byte-serially, LSB byte first, one byte per clock.
- Chains the carry between bytes, assembles the wide result and status, and returns them over a valid/ready response channel.
- Sits between the command issuer and a ula_8_bits instance at the same hierarchy level; it is the only driver of the ALU inputs.

Parameters:
- NBYTES, 4, operand width in bytes (>=2); wide operand width W = 8*NBYTES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_m  in  1  ALU mode (1 logic, 0 arithmetic)
- cmd_s  in  4  ALU function select
- cmd_cin  in  1  raw ALU c_in for byte 0
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed when valid&ready
- rsp_f  out  W  wide result
- rsp_cout  out  1  raw alu_cout of final byte; 0 in logic mode
- rsp_ovf  out  1  alu_ovf of final byte; 0 in logic mode
- rsp_zero  out  1  rsp_f == 0
- rsp_eq  out  1  AND of alu_a_eq_b over all bytes
- alu_a  out  8  ALU operand A byte
- alu_b  out  8  ALU operand B byte
- alu_s  out  4  ALU select
- alu_m  out  1  ALU mode
- alu_cin  out  1  ALU carry in
- alu_f  in  8  ALU result
- alu_cout  in  1  ALU carry out
- alu_ovf  in  1  ALU overflow
- alu_a_eq_b  in  1  ALU equality output

Behaviour:
- Clocking and reset are decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_ovf=0, rsp_zero=0, rsp_eq=0, all operand/index/carry registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: capture cmd_a, cmd_b, cmd_m, cmd_s; carry<=cmd_cin; idx<=0; eq_acc<=1; go to RUN.
- RUN:
  - cmd_ready=0.
  - alu_a and alu_b are combinational selects of byte idx from the captured operands.
  - alu_s and alu_m come from the captured registers; alu_cin=carry.
  - Each cycle: result byte idx <= alu_f; eq_acc <= eq_acc & alu_a_eq_b.
  - Carry update, arithmetic mode: carry <= inv ? ~alu_cout : alu_cout. inv=1 for s in {0000,0010,0011,0110,0111,1011} (the ALU reports a complemented carry for these).
  - Carry update, logic mode: carry held at cmd_cin.
  - At idx=NBYTES-1: latch rsp_cout/rsp_ovf from raw alu_cout/alu_ovf (forced 0 if m=1); compute rsp_zero over the assembled word; rsp_eq <= final eq_acc; go to DONE. Otherwise idx++.
- DONE:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
- Latency: accept at cycle T; RUN occupies T+1..T+NBYTES; rsp_valid first asserted at T+NBYTES+1. Throughput is one command per NBYTES+2 cycles when rsp_ready is held high.
- ALU input defaults outside RUN: alu_a=0, alu_b=0, alu_s=0, alu_m=1, alu_cin=0.
- cmd_valid is ignored outside IDLE. Command fields need only be stable in the accept cycle.
- Reset mid-RUN or mid-DONE: the command is discarded and all outputs return to reset values immediately.

Optional Feature:
- ULA_SEQ_BACK2BACK_EN
  - Defined: in DONE, cmd_ready = rsp_ready. A command accepted in the same cycle as the response handshake goes directly to RUN. Throughput becomes one command per NBYTES+1 cycles.
  - Undefined: cmd_ready=0 in DONE; a mandatory IDLE cycle separates commands.

Decomposition:
- Package ula_seq_pkg:
  - state enum (IDLE, RUN, DONE);
  - 4-bit constants for the ALU select codes used by the bench (ADD=1001, SUB_M1=0110);
  - function carry_inverted(s) returning inv.
- No sub-module. ula_8_bits is instantiated beside this block by the parent and by the bench.

Test Plan (NBYTES=4, ula_8_bits connected):
- m=0, s=1001, cin=0, A=0x000000FF, B=0x00000001 -> F=0x00000100, cout=0, ovf=0, zero=0; rsp_valid exactly 5 cycles after accept.
- m=0, s=1001, cin=0, A=0xFFFFFFFF, B=0x00000001 -> F=0x00000000, cout=1, zero=1.
- m=0, s=0110, cin=1, A=0x00000100, B=0x00000001 (A-B via inverted chain) -> F=0x000000FF, rsp_cout=0, ovf=0.
- m=0, s=1001, cin=0, A=0x7FFFFFFF, B=0x00000001 -> F=0x80000000, ovf=1, cout=0.
- m=1, s=0110, A=0xF0F0F0F0, B=0xFF00FF00 -> F=0x0FF00FF0, cout=0, ovf=0; cmd_ready=0 throughout RUN/DONE with cmd_valid held high.
- Response backpressure and reset:
  - hold rsp_ready=0 for 3 cycles in DONE -> rsp_valid and rsp_f stable;
  - assert rst_n=0 during RUN -> all outputs at reset values the same cycle;
  - the next command (0x12345678+0x11111111) returns 0x23456789.
